// File: rtl/fwd_pkg.sv
// Shared types and encodings for the forwarding/hazard controller: operand-mux
// select codes, default register-address width and the pipeline stage record.
package fwd_pkg;

  localparam int REG_AW_DEF = 3;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwr;
    logic                  memrd;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '{rd: '0, regwr: 1'b0, memrd: 1'b0};

  // A stage record produces a value this operand needs (r0 never counts).
  function automatic logic rd_hit(input logic [REG_AW_DEF-1:0] src,
                                  input logic use_src,
                                  input stage_rec_t rec);
    return use_src && (src != '0) && rec.regwr && (rec.rd == src);
  endfunction

  // Youngest producer wins: EX/MEM result before MEM/WB result.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW_DEF-1:0] src,
                                         input logic use_src,
                                         input stage_rec_t ex,
                                         input stage_rec_t mem);
    if (rd_hit(src, use_src, ex))
      return SEL_EXMEM;
    else if (rd_hit(src, use_src, mem))
      return SEL_MEMWB;
    else
      return SEL_RF;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage record {rd, regwr, memrd}; 'bubble' loads a no-op record
// instead of the incoming one.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= BUBBLE;
    else if (bubble)
      q <= BUBBLE;
    else
      q <= d;
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and hazard-stall controller for a 5-stage pipeline.
// Define FWD_CTRL_FORWARDING_EN for forwarding; otherwise every RAW hazard stalls.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              id_valid,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall,
  output logic [15:0]       stall_cnt
);

  stage_rec_t id_rec;
  stage_rec_t ex_p0;
  stage_rec_t mem_p1;
  stage_rec_t wb_p2;
  logic       unused_wb;

  assign id_rec = '{rd: id_rd, regwr: id_regwr & id_valid, memrd: id_memrd & id_valid};

  // ID -> EX boundary: a stall turns the EX entry into a bubble
  fwd_stage_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .bubble (stall),
    .d      (id_rec),
    .q      (ex_p0)
  );

  // EX -> MEM boundary
  fwd_stage_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (ex_p0),
    .q      (mem_p1)
  );

  // MEM -> WB boundary; the register file is write-first, so WB never causes a hazard
  fwd_stage_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (mem_p1),
    .q      (wb_p2)
  );

  assign unused_wb = ^wb_p2;

`ifdef FWD_CTRL_FORWARDING_EN
  logic ld_hit_rs;
  logic ld_hit_rt;

  // Only a load in EX cannot be forwarded in time; its result is ready from MEM/WB next cycle.
  assign ld_hit_rs = id_use_rs && (ex_p0.rd != '0) && (ex_p0.rd == id_rs);
  assign ld_hit_rt = id_use_rt && (ex_p0.rd != '0) && (ex_p0.rd == id_rt);
  assign stall     = ex_p0.memrd && (ld_hit_rs || ld_hit_rt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a <= SEL_RF;
      sel_b <= SEL_RF;
    end else if (stall) begin
      sel_a <= SEL_RF;
      sel_b <= SEL_RF;
    end else begin
      sel_a <= fwd_sel(id_rs, id_use_rs, ex_p0, mem_p1);
      sel_b <= fwd_sel(id_rt, id_use_rt, ex_p0, mem_p1);
    end
  end
`else
  assign stall = rd_hit(id_rs, id_use_rs, ex_p0)  || rd_hit(id_rt, id_use_rt, ex_p0) ||
                 rd_hit(id_rs, id_use_rs, mem_p1) || rd_hit(id_rt, id_use_rt, mem_p1);
  assign sel_a = SEL_RF;
  assign sel_b = SEL_RF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed vector bench for fwd_ctrl; expectations follow FWD_CTRL_FORWARDING_EN.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_regwr, id_memrd, id_valid;
  logic [1:0] sel_a, sel_b;
  logic       stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] rs, rt, rd;
    logic       use_rs, use_rt, regwr, memrd, valid;
    logic       exp_stall;
    logic [1:0] exp_sa, exp_sb;
  } vec_t;

  vec_t vecs[$];

  fwd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_rd     (id_rd),
    .id_regwr  (id_regwr),
    .id_memrd  (id_memrd),
    .id_valid  (id_valid),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] rs, input logic urs, input logic [2:0] rt, input logic urt,
                     input logic [2:0] rd, input logic wr, input logic mr, input logic v,
                     input logic st, input logic [1:0] sa, input logic [1:0] sb);
    vec_t x;
    x.rs = rs; x.use_rs = urs; x.rt = rt; x.use_rt = urt;
    x.rd = rd; x.regwr = wr; x.memrd = mr; x.valid = v;
    x.exp_stall = st; x.exp_sa = sa; x.exp_sb = sb;
    vecs.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    id_use_rs = x.use_rs; id_use_rt = x.use_rt;
    id_regwr = x.regwr; id_memrd = x.memrd; id_valid = x.valid;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("%s[%0d].stall", tag, i), {15'd0, stall}, {15'd0, vecs[i].exp_stall});
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].sel_a", tag, i), {14'd0, sel_a}, {14'd0, vecs[i].exp_sa});
      check($sformatf("%s[%0d].sel_b", tag, i), {14'd0, sel_b}, {14'd0, vecs[i].exp_sb});
    end
    vecs.delete();
  endtask

  initial begin
    vec_t x;
    rst = 1'b1;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwr = 1'b0; id_memrd = 1'b0; id_valid = 1'b0;
    #2;
    check("reset.stall", {15'd0, stall}, 16'd0);
    check("reset.sel_a", {14'd0, sel_a}, 16'd0);
    check("reset.sel_b", {14'd0, sel_b}, 16'd0);
    check("reset.stall_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifdef FWD_CTRL_FORWARDING_EN
    //   rs urs rt urt rd wr mr v  stall sa     sb
    add(0, 1, 0, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00); // add r1
    add(1, 1, 3, 1, 2, 1, 0, 1, 0, 2'b01, 2'b00); // add r2,r1,r3: EX forward
    add(0, 1, 0, 1, 4, 1, 0, 1, 0, 2'b00, 2'b00); // producer r4
    add(0, 1, 0, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00); // unrelated
    add(0, 1, 4, 1, 7, 1, 0, 1, 0, 2'b00, 2'b10); // reads r4 in rt: MEM forward
    add(0, 1, 0, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00); // write r5
    add(5, 1, 0, 1, 5, 1, 0, 1, 0, 2'b01, 2'b00); // write r5 again
    add(5, 1, 5, 1, 1, 1, 0, 1, 0, 2'b01, 2'b01); // r5 in EX and MEM: EX wins
    add(0, 1, 0, 0, 6, 1, 1, 1, 0, 2'b00, 2'b00); // lw r6
    add(6, 1, 6, 1, 7, 1, 0, 1, 1, 2'b00, 2'b00); // add r7,r6,r6: load-use stall
    add(6, 1, 6, 1, 7, 1, 0, 1, 0, 2'b10, 2'b10); // replay: load now in MEM
    add(1, 1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00); // writes r0
    add(0, 1, 0, 1, 3, 1, 0, 1, 0, 2'b00, 2'b00); // reads r0: never forwarded
    add(3, 0, 3, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00); // r3 in EX but operands unused
    add(0, 1, 0, 1, 2, 1, 1, 1, 0, 2'b00, 2'b00); // lw r2
    add(2, 0, 2, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00); // r2 unused: no load-use stall
    add(0, 0, 0, 0, 3, 1, 0, 0, 0, 2'b00, 2'b00); // invalid slot claiming r3
    add(3, 1, 3, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00); // r3 reader: nothing to forward
    run_table("fwd");
    check("fwd.stall_cnt", stall_cnt, 16'd1);
`else
    add(0, 1, 0, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00); // add r1
    add(1, 1, 3, 1, 2, 1, 0, 1, 1, 2'b00, 2'b00); // add r2,r1,r3: r1 in EX
    add(1, 1, 3, 1, 2, 1, 0, 1, 1, 2'b00, 2'b00); // r1 in MEM
    add(1, 1, 3, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00); // r1 in WB: go
    run_table("nofwd_a");
    check("nofwd.stall_cnt_a", stall_cnt, 16'd2);
    add(0, 1, 0, 1, 4, 1, 0, 1, 0, 2'b00, 2'b00); // producer r4
    add(0, 1, 0, 1, 2, 1, 0, 1, 0, 2'b00, 2'b00); // unrelated
    add(0, 1, 4, 1, 7, 1, 0, 1, 1, 2'b00, 2'b00); // r4 in MEM
    add(0, 1, 4, 1, 7, 1, 0, 1, 0, 2'b00, 2'b00); // r4 in WB: go
    add(0, 1, 0, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00); // writes r0
    add(0, 1, 0, 1, 5, 1, 0, 1, 0, 2'b00, 2'b00); // reads r0: no stall
    add(5, 0, 5, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00); // r5 in EX, operands unused
    add(0, 0, 0, 0, 6, 1, 0, 0, 0, 2'b00, 2'b00); // invalid slot claiming r6
    add(6, 1, 6, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00); // r6 reader: no stall
    run_table("nofwd_b");
    check("nofwd.stall_cnt_b", stall_cnt, 16'd3);
`endif

    // Reset in the middle of a load-use stall (stalls in both builds)
    add(0, 1, 0, 1, 1, 1, 1, 1, 0, 2'b00, 2'b00); // lw r1
    run_table("pre_rst");
    @(negedge clk);
    x.rs = 1; x.use_rs = 1; x.rt = 0; x.use_rt = 0; x.rd = 2;
    x.regwr = 1; x.memrd = 0; x.valid = 1;
    drive(x);
    #1;
    check("midstall.stall", {15'd0, stall}, 16'd1);
    rst = 1'b1;
    #1;
    check("rst.stall", {15'd0, stall}, 16'd0);
    check("rst.sel_a", {14'd0, sel_a}, 16'd0);
    check("rst.sel_b", {14'd0, sel_b}, 16'd0);
    check("rst.stall_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst.stall", {15'd0, stall}, 16'd0);
    @(posedge clk);
    #1;
    check("post_rst.sel_a", {14'd0, sel_a}, 16'd0);
    check("post_rst.stall_cnt", stall_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected end before 20000");
    $fatal(1);
  end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 3: register-address width (8 GPRs, r0 hardwired zero).
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs, id_rt  input  REG_AW: source operands of the decode-stage instruction.
REQ-005 SHALL have ports id_use_rs, id_use_rt  input  1: the operand is actually read.
REQ-006 SHALL have port id_rd  input  REG_AW: destination of the decode-stage instruction.
REQ-007 SHALL have ports id_regwr, id_memrd  input  1: writes a register; is a load.
REQ-008 SHALL have port id_valid  input  1: the decode-stage instruction is real (not a bubble).
REQ-009 SHALL have ports sel_a, sel_b  output  2: registered select codes for the EX-stage 3:1 operand muxes.
REQ-010 SHALL have port stall  output  1: combinational; hold PC and IF/ID, bubble EX.
REQ-011 SHALL have port stall_cnt  output  16: saturating count of stall cycles.

Function
REQ-012 SHALL use select encoding 2'b00 = register file, 2'b01 = EX/MEM result, 2'b10 = MEM/WB result; 2'b11 SHALL never be driven.
REQ-013 SHALL track three stage records (EX, MEM, WB), each holding {rd, regwr, memrd}.
REQ-014 SHALL advance EX<-ID, MEM<-EX, WB<-MEM each cycle while stall=0.
REQ-015 SHALL, while stall=1, load EX with a bubble (regwr=0, memrd=0) and still advance MEM<-EX and WB<-MEM.
REQ-016 SHALL treat ID as a bubble (regwr=0, memrd=0) when id_valid=0.
REQ-017 SHALL compute next sel_a as 01 when id_use_rs, EX.regwr and EX.rd==id_rs; otherwise 10 when MEM.regwr and MEM.rd==id_rs; otherwise 00.
REQ-018 SHALL compute next sel_b identically, using id_rt and id_use_rt.
REQ-019 SHALL give EX-stage matches priority over MEM-stage matches (youngest producer wins).
REQ-020 SHALL never forward for an operand equal to 0; sel SHALL be 00.
REQ-021 SHALL register sel_a/sel_b on the edge on which the instruction enters EX, giving 1-cycle latency from ID.
REQ-022 SHALL force sel_a/sel_b to 00 on a stall edge, since the EX content is then a bubble.
REQ-023 SHALL assert stall when EX.memrd and EX.rd!=0 and EX.rd matches a used id_rs/id_rt (load-use hazard).
REQ-024 SHALL, on the cycle after a load-use stall, have the load in MEM, so the dependent instruction enters EX with sel=10; the stall lasts exactly 1 cycle.
REQ-025 SHALL increment stall_cnt on each clock with stall=1, holding at 16'hFFFF.

Reset
REQ-026 SHALL, on rst=1, immediately clear all stage records to bubbles, sel_a=sel_b=00, and stall_cnt=0; stall therefore reads 0.
REQ-027 SHALL, when reset occurs mid-stall, drop the hazard, with no pending stall after release.

Configuration
REQ-028 SHALL, when macro FWD_CTRL_FORWARDING_EN is defined, implement forwarding as in REQ-017..REQ-024.
REQ-029 SHALL, when FWD_CTRL_FORWARDING_EN is undefined, tie sel_a=sel_b=00 and assert stall on any used-operand match with EX or MEM (regwr, rd!=0), giving up to 2 stall cycles; WB matches SHALL not stall, because the register file is write-first.

Structure
REQ-030 SHALL place the select encodings, REG_AW default, and the stage-record struct/typedef in shared package fwd_pkg.
REQ-031 SHALL implement each stage record as an instance of sub-module fwd_stage_reg (async reset, bubble-insert input).

Verification
REQ-032 SHALL verify ALU-ALU forwarding: add r1 then add r2,r1,r3 back-to-back -> sel_a=01 in the dependent EX cycle, and stall=0.
REQ-033 SHALL verify the distance-2 path: producer of r4, then an unrelated instruction, then a reader of r4 in rt -> sel_b=10.
REQ-034 SHALL verify priority: r5 written in both EX and MEM, ID reads r5 -> sel=01, not 10.
REQ-035 SHALL verify load-use: lw r6, then add r7,r6,r6 -> stall=1 for exactly 1 cycle; then sel_a=sel_b=10; stall_cnt=1.
REQ-036 SHALL verify r0 and unused operands: producer writes r0 or id_use_rs=0 -> sel=00 and stall=0.
REQ-037 SHALL verify the no-forwarding build and reset: with the macro undefined, back-to-back r1 dependency -> stall for 2 cycles; rst asserted mid-stall -> stall=0, sel=00, and stall_cnt=0 immediately.
